// File: rtl/edge_param_streamer.sv
// Per-context edge parameter table driving a row of neighbor links; prefetches the next
// context into a shadow bank and swaps it in on the write-to-memory edge. Option: EDGE_PARAM_PARITY_EN.
module edge_param_streamer #(
    parameter int unsigned NUM_EDGES    = 8,
    parameter int unsigned MAX_WEIGHT   = 2,
    parameter int unsigned NUM_CONTEXTS = 2,
    parameter int unsigned STAGE_WIDTH  = 3,
    parameter logic [STAGE_WIDTH-1:0] STAGE_IDLE               = STAGE_WIDTH'(0),
    parameter logic [STAGE_WIDTH-1:0] STAGE_PARAMETERS_LOADING = STAGE_WIDTH'(1),
    parameter logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM       = STAGE_WIDTH'(5),
    localparam int unsigned LBW = $clog2(MAX_WEIGHT + 1),
    localparam int unsigned CW  = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [STAGE_WIDTH-1:0]   global_stage,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LBW+1:0]           in_data,
    input  logic                     in_last,
`ifdef EDGE_PARAM_PARITY_EN
    input  logic                     in_parity,
`endif
    output logic [NUM_EDGES*LBW-1:0] weight_out,
    output logic [NUM_EDGES*2-1:0]   boundary_condition_out,
    output logic                     do_not_store,
    output logic                     reset_edge,
    output logic [CW-1:0]            context_id,
    output logic                     load_done,
    output logic                     fetch_busy,
    output logic                     error
);
    localparam int unsigned DW    = LBW + 2;
    localparam int unsigned DEPTH = NUM_CONTEXTS * NUM_EDGES;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned EW    = (NUM_EDGES > 1) ? $clog2(NUM_EDGES) : 1;
    localparam int unsigned LCW   = $clog2(NUM_CONTEXTS + 1);
    localparam int unsigned FCW   = $clog2(NUM_EDGES + 1);
`ifdef EDGE_PARAM_PARITY_EN
    localparam int unsigned MW    = DW + 1;
`else
    localparam int unsigned MW    = DW;
`endif

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FETCH, S_READY} state_t;
    state_t state, state_n;

    logic [STAGE_WIDTH-1:0] stage_q, stage_qq;
    logic                   load_start, wtm;
    logic [EW-1:0]          wr_edge;
    logic [LCW-1:0]         wr_ctx, ctx_after, loaded_ctx;
    logic                   accept, word_ok, edge_wrap, partial, finish;
    logic [CW-1:0]          fetch_ctx, cid_next, fetch_after_swap, first_fetch;
    logic [FCW-1:0]         fetch_cnt;
    logic                   fetch_last, swap, fetch_clash, rd_par_bad;
    logic [AW-1:0]          wr_addr, rd_addr;
    logic [MW-1:0]          wr_word, rd_word;
    logic [MW-1:0]          mem [DEPTH];
    logic [DW-1:0]          out_reg [NUM_EDGES];
    logic [DW-1:0]          shadow  [NUM_EDGES];

`ifdef EDGE_PARAM_PARITY_EN
    assign word_ok    = ~(^{in_data, in_parity});
    assign wr_word    = {in_parity, in_data};
    assign rd_par_bad = ^rd_word;
`else
    assign word_ok    = 1'b1;
    assign wr_word    = in_data;
    assign rd_par_bad = 1'b0;
`endif

    function automatic logic [CW-1:0] wrap_ctx(input logic [CW-1:0] c, input logic [LCW-1:0] n);
        if (LCW'(c) + LCW'(1) >= n) return '0;
        else return c + CW'(1);
    endfunction

    assign load_start = (stage_q == STAGE_PARAMETERS_LOADING) && (stage_qq != STAGE_PARAMETERS_LOADING);
    assign wtm        = (stage_q == STAGE_WRITE_TO_MEM);
    assign in_ready   = (state == S_LOAD) && (stage_q == STAGE_PARAMETERS_LOADING) && !load_start
                        && (wr_ctx < LCW'(NUM_CONTEXTS));
    assign accept     = in_valid && in_ready;
    assign edge_wrap  = (wr_edge == EW'(NUM_EDGES - 1));
    assign ctx_after  = wr_ctx + LCW'(word_ok && edge_wrap);
    // A context is partial if the edge pointer would be non-zero after this word.
    assign partial    = word_ok ? !edge_wrap : (wr_edge != '0);
    assign finish     = accept && (in_last || (word_ok && edge_wrap && wr_ctx == LCW'(NUM_CONTEXTS - 1)));
    assign first_fetch = (ctx_after > LCW'(1)) ? CW'(1) : '0;
    assign cid_next         = wrap_ctx(context_id, loaded_ctx);
    assign fetch_after_swap = wrap_ctx(cid_next, loaded_ctx);
    assign fetch_last = (fetch_cnt == FCW'(NUM_EDGES));
    assign fetch_busy = (state == S_FETCH);
    assign wr_addr    = AW'(32'(wr_ctx) * NUM_EDGES + 32'(wr_edge));
    assign rd_addr    = (fetch_cnt < FCW'(NUM_EDGES)) ? AW'(32'(fetch_ctx) * NUM_EDGES + 32'(fetch_cnt)) : '0;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n     = state;
        swap        = 1'b0;
        fetch_clash = 1'b0;
        case (state)
            S_LOAD:  if (finish) state_n = (ctx_after == '0) ? S_IDLE : S_FETCH;
            S_FETCH: begin
                fetch_clash = wtm && !do_not_store;
                if (fetch_last) state_n = S_READY;
            end
            S_READY: if (wtm && !do_not_store) begin
                swap    = 1'b1;
                state_n = S_FETCH;
            end
            default: ;
        endcase
        if (load_start) state_n = S_LOAD;
    end

    always_ff @(posedge clk) begin
        if (accept && word_ok) mem[wr_addr] <= wr_word;
        rd_word <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q      <= STAGE_IDLE;
            stage_qq     <= STAGE_IDLE;
            reset_edge   <= 1'b0;
            wr_edge      <= '0;
            wr_ctx       <= '0;
            loaded_ctx   <= '0;
            load_done    <= 1'b0;
            do_not_store <= 1'b0;
            context_id   <= '0;
            fetch_ctx    <= '0;
            fetch_cnt    <= '0;
            error        <= 1'b0;
            for (int unsigned e = 0; e < NUM_EDGES; e++) begin
                out_reg[e] <= '0;
                shadow[e]  <= '0;
            end
        end else begin
            stage_q    <= global_stage;
            stage_qq   <= stage_q;
            reset_edge <= load_start;
            if (load_start) begin
                wr_edge      <= '0;
                wr_ctx       <= '0;
                loaded_ctx   <= '0;
                load_done    <= 1'b0;
                do_not_store <= 1'b0;
                context_id   <= '0;
                fetch_cnt    <= '0;
                for (int unsigned e = 0; e < NUM_EDGES; e++) out_reg[e] <= '0;
            end else begin
                case (state)
                    S_LOAD: if (accept) begin
                        if (word_ok) begin
                            wr_edge <= edge_wrap ? '0 : wr_edge + EW'(1);
                            if (edge_wrap) wr_ctx <= wr_ctx + LCW'(1);
                            if (wr_ctx == '0) out_reg[wr_edge] <= in_data;
                        end else begin
                            error <= 1'b1;
                        end
                        if (finish) begin
                            loaded_ctx <= ctx_after;
                            fetch_ctx  <= first_fetch;
                            fetch_cnt  <= '0;
                            if (ctx_after == '0) begin
                                error <= 1'b1;
                            end else begin
                                load_done    <= 1'b1;
                                do_not_store <= (ctx_after <= LCW'(1));
                                if (partial) error <= 1'b1;
                            end
                        end
                    end
                    S_FETCH: begin
                        // Read data trails the address by one cycle, hence the count to NUM_EDGES.
                        fetch_cnt <= fetch_cnt + FCW'(1);
                        if (fetch_cnt != '0) begin
                            shadow[EW'(fetch_cnt - FCW'(1))] <= rd_word[DW-1:0];
                            if (rd_par_bad) error <= 1'b1;
                        end
                        if (fetch_clash) error <= 1'b1;
                    end
                    S_READY: if (swap) begin
                        for (int unsigned e = 0; e < NUM_EDGES; e++) out_reg[e] <= shadow[e];
                        context_id <= cid_next;
                        fetch_ctx  <= fetch_after_swap;
                        fetch_cnt  <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        weight_out             = '0;
        boundary_condition_out = '0;
        for (int unsigned e = 0; e < NUM_EDGES; e++) begin
            weight_out[e*LBW +: LBW]         = out_reg[e][DW-1:2];
            boundary_condition_out[e*2 +: 2] = out_reg[e][1:0];
        end
    end
endmodule

// File: tb/tb_edge_param_streamer.sv
// Scoreboard bench for edge_param_streamer: directed loads and context swaps with
// cycle-stamped expectations checked by an independent negedge monitor.
module tb_edge_param_streamer;
    localparam int unsigned NE = 4, NC = 2, MWT = 2, SW = 3;
    localparam logic [SW-1:0] ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_OTHER = 3'd2, ST_WTM = 3'd5;
    localparam logic [31:0] M_BC = 32'h0000_00FF, M_W = 32'h0000_FF00, M_CID = 32'h0001_0000,
                            M_ERR = 32'h0002_0000, M_FB = 32'h0004_0000, M_DNS = 32'h0008_0000,
                            M_LD = 32'h0010_0000, M_RE = 32'h0020_0000, M_RDY = 32'h0040_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic [SW-1:0] global_stage;
    logic          in_valid, in_ready, in_last;
    logic [3:0]    in_data;
`ifdef EDGE_PARAM_PARITY_EN
    logic          in_parity;
`endif
    logic [7:0]    weight_out, bc_out;
    logic          do_not_store, reset_edge, context_id, load_done, fetch_busy, error;

    edge_param_streamer #(
        .NUM_EDGES(NE), .MAX_WEIGHT(MWT), .NUM_CONTEXTS(NC), .STAGE_WIDTH(SW),
        .STAGE_IDLE(ST_IDLE), .STAGE_PARAMETERS_LOADING(ST_LOAD), .STAGE_WRITE_TO_MEM(ST_WTM)
    ) dut (
        .clk(clk), .reset(reset), .global_stage(global_stage),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
`ifdef EDGE_PARAM_PARITY_EN
        .in_parity(in_parity),
`endif
        .weight_out(weight_out), .boundary_condition_out(bc_out),
        .do_not_store(do_not_store), .reset_edge(reset_edge), .context_id(context_id),
        .load_done(load_done), .fetch_busy(fetch_busy), .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] obs;
    assign obs = {9'd0, in_ready, reset_edge, load_done, do_not_store, fetch_busy, error,
                  context_id, weight_out, bc_out};

    int          q_cyc[$];
    string       q_name[$];
    logic [31:0] q_val[$], q_mask[$];
    int checks = 0, errors = 0;

    task automatic sb_push(input int ofs, input string name, input logic [31:0] val, input logic [31:0] mask);
        q_cyc.push_back(cyc + ofs);
        q_name.push_back(name);
        q_val.push_back(val);
        q_mask.push_back(mask);
    endtask

    always @(negedge clk) begin
        for (int i = q_cyc.size() - 1; i >= 0; i--) begin
            if (q_cyc[i] <= cyc) begin
                checks++;
                if (q_cyc[i] != cyc || (obs & q_mask[i]) !== (q_val[i] & q_mask[i])) begin
                    errors++;
                    $display("FAIL %s cyc %0d: got %h want %h (mask %h)", q_name[i], cyc,
                             obs & q_mask[i], q_val[i] & q_mask[i], q_mask[i]);
                end
                q_cyc.delete(i); q_name.delete(i); q_val.delete(i); q_mask.delete(i);
            end
        end
    end

    function automatic logic [31:0] v(input logic [7:0] w, input logic [7:0] bc, input logic cid);
        return {15'd0, cid, w, bc};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [1:0] w, input logic [1:0] bc, input logic last);
        in_valid = 1'b1; in_data = {w, bc}; in_last = last;
`ifdef EDGE_PARAM_PARITY_EN
        in_parity = ^{w, bc};
`endif
        tick(1);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; global_stage = ST_IDLE; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
`ifdef EDGE_PARAM_PARITY_EN
        in_parity = 1'b0;
`endif
        tick(2);
        reset = 1'b0;
        sb_push(0, "reset_state", 32'd0, 32'h007F_FFFF);
    endtask

    task automatic start_load();
        global_stage = ST_LOAD;
        tick(2);
        sb_push(0, "reset_edge_hi", M_RE | M_RDY, M_RE | M_RDY | M_LD | M_DNS | M_W | M_CID);
        sb_push(1, "reset_edge_lo", M_RDY, M_RE | M_RDY);
    endtask

    task automatic wtm_pulse();
        global_stage = ST_WTM;
        tick(1);
        global_stage = ST_OTHER;
    endtask

    logic [1:0] wa[8]     = '{2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd1, 2'd2, 2'd0};
    logic [1:0] wc[8]     = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1};
    logic [1:0] bcb[4]    = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] pre_w[3]  = '{8'h86, 8'h25, 8'h86};
    logic [7:0] post_w[3] = '{8'h25, 8'h86, 8'h25};
    logic       pre_c[3]  = '{1'b0, 1'b1, 1'b0};
    logic       post_c[3] = '{1'b1, 1'b0, 1'b1};

    initial begin
        // Two-context load, three swaps, then a swap request during prefetch.
        do_reset();
        start_load();
        for (int i = 0; i < 8; i++) begin
            send(wa[i], 2'd0, i == 7);
            if (i == 0) sb_push(0, "ctx0_word0", v(8'h02, 8'h00, 1'b0), M_W);
        end
        sb_push(0, "load_done_a", M_LD | M_FB | v(8'h86, 8'h00, 1'b0),
                M_LD | M_DNS | M_FB | M_ERR | M_RDY | M_W | M_BC | M_CID);
        sb_push(4, "fetch_busy_end", M_FB, M_FB);
        sb_push(5, "fetch_idle", 32'd0, M_FB);
        global_stage = ST_OTHER;
        tick(8);
        for (int p = 0; p < 3; p++) begin
            sb_push(1, "pre_swap", v(pre_w[p], 8'h00, pre_c[p]), M_W | M_CID | M_ERR);
            sb_push(2, "swap", v(post_w[p], 8'h00, post_c[p]), M_W | M_CID | M_ERR | M_DNS);
            wtm_pulse();
            if (p < 2) tick(7);
        end
        tick(1);
        sb_push(2, "clash_error", M_ERR | v(8'h25, 8'h00, 1'b1), M_ERR | M_W | M_CID);
        sb_push(8, "clash_sticky", M_ERR | v(8'h25, 8'h00, 1'b1), M_ERR | M_W | M_CID | M_FB);
        wtm_pulse();
        tick(10);

        // Single context: do_not_store holds outputs; words outside LOAD are ignored.
        do_reset();
        start_load();
        for (int i = 0; i < 4; i++) send(wc[i], bcb[i], i == 3);
        sb_push(0, "load_single", M_LD | M_DNS | M_FB | v(8'h69, 8'h39, 1'b0),
                M_LD | M_DNS | M_FB | M_ERR | M_W | M_BC | M_CID);
        global_stage = ST_OTHER;
        tick(6);
        in_valid = 1'b1; in_data = 4'hF; in_last = 1'b1;
        sb_push(0, "ignored_word_rdy", 32'd0, M_RDY);
        tick(1);
        in_valid = 1'b0; in_last = 1'b0;
        sb_push(0, "ignored_word_out", v(8'h69, 8'h39, 1'b0), M_W | M_BC);
        sb_push(2, "dns_hold", M_DNS | v(8'h69, 8'h39, 1'b0), M_DNS | M_W | M_BC | M_CID | M_ERR | M_FB);
        wtm_pulse();
        tick(4);

        // Early in_last drops the partial context; re-entry reloads the table.
        do_reset();
        start_load();
        for (int i = 0; i < 6; i++) send(wa[i], 2'd0, i == 5);
        sb_push(0, "partial_load", M_ERR | M_LD | M_DNS | M_FB | v(8'h86, 8'h00, 1'b0),
                M_ERR | M_LD | M_DNS | M_FB | M_W | M_CID);
        global_stage = ST_OTHER;
        tick(6);
        sb_push(2, "partial_hold", M_DNS | M_ERR | v(8'h86, 8'h00, 1'b0), M_DNS | M_ERR | M_W | M_CID);
        wtm_pulse();
        tick(3);
        start_load();
        for (int i = 0; i < 8; i++) send(wc[i], 2'd0, i == 7);
        sb_push(0, "reload_done", M_LD | M_FB | M_ERR | v(8'h69, 8'h00, 1'b0),
                M_LD | M_DNS | M_FB | M_ERR | M_W | M_CID);
        global_stage = ST_OTHER;
        tick(6);
        sb_push(2, "reload_swap", M_ERR | v(8'h5A, 8'h00, 1'b1), M_ERR | M_DNS | M_W | M_CID);
        wtm_pulse();
        tick(8);

`ifdef EDGE_PARAM_PARITY_EN
        // Bad-parity word is discarded without advancing the write pointer.
        do_reset();
        start_load();
        send(2'd2, 2'd0, 1'b0);
        send(2'd1, 2'd0, 1'b0);
        sb_push(0, "parity_pre", 32'd0, M_ERR);
        in_valid = 1'b1; in_data = 4'b0100; in_parity = 1'b0; in_last = 1'b0;
        tick(1);
        in_valid = 1'b0;
        sb_push(0, "parity_err", M_ERR | M_RDY, M_ERR | M_RDY);
        send(2'd0, 2'd0, 1'b0);
        send(2'd2, 2'd0, 1'b1);
        sb_push(0, "parity_index", M_ERR | M_LD | M_DNS | v(8'h86, 8'h00, 1'b0),
                M_ERR | M_LD | M_DNS | M_W | M_CID);
        tick(8);
`endif

        tick(3);
        checks++;
        if (q_cyc.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q_cyc.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
